// File: rtl/regfile_mp.sv
// Multi-port integer register file with a sequential clear engine after
// reset, optional write-to-read bypass, and an optional hard-wired zero entry.
// All state updates happen on the rising edge of clk.
module regfile_mp #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int AW       = 5,
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                ready,
    input  logic [NWR-1:0]      we,
    input  logic [NWR*AW-1:0]   wa,
    input  logic [NWR*XLEN-1:0] wd,
    input  logic [NRD*AW-1:0]   ra,
    output logic [NRD*XLEN-1:0] rd
);

    typedef enum logic {INIT, RUN} state_e;

    localparam logic [AW:0] NREGS_W  = (AW+1)'(NREGS);
    localparam logic [AW:0] LAST_IDX = (AW+1)'(NREGS - 1);
    localparam logic [AW:0] ONE_W    = (AW+1)'(1);

    state_e          state_q, state_d;
    logic [AW:0]     init_idx_q, init_idx_d;
    logic [XLEN-1:0] mem_q [NREGS];
    logic [NWR-1:0]  wr_ok;

    // Init engine: walk init_idx over every entry, then stay in RUN.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d    = state_q;
        init_idx_d = init_idx_q;
        if (state_q == INIT) begin
            init_idx_d = init_idx_q + ONE_W;
            if (init_idx_q == LAST_IDX) begin
                state_d = RUN;
            end
        end
    end

    // State register; reset restarts the clear sequence at entry 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= INIT;
            init_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            init_idx_q <= init_idx_d;
        end
    end

    assign ready = (state_q == RUN);

    // A write port is effective only in RUN, in range, and not to a zero entry.
    always_comb begin
        wr_ok = '0;
        for (int i = 0; i < NWR; i++) begin
            wr_ok[i] = (state_q == RUN) && we[i]
                     && ({1'b0, wa[i*AW +: AW]} < NREGS_W)
                     && !((ZERO_REG != 0) && (wa[i*AW +: AW] == '0));
        end
    end

    // Storage array: cleared by the init engine, written by the ports in RUN.
    // NOTE: the array has no reset branch; asynchronous reset on a storage
    // array prevents RAM inference, and the init engine clears it instead.
    always_ff @(posedge clk) begin
        if (state_q == INIT) begin
            mem_q[init_idx_q[AW-1:0]] <= '0;
        end else begin
            // NOTE: non-blocking assignments to one entry resolve to the last
            // one executed, so ascending port order gives the highest index
            // priority on a conflict.
            for (int i = 0; i < NWR; i++) begin
                if (wr_ok[i]) begin
                    mem_q[wa[i*AW +: AW]] <= wd[i*XLEN +: XLEN];
                end
            end
        end
    end

    // Combinational read ports with optional same-cycle forwarding.
    always_comb begin
        logic [AW-1:0] ra_j;
        rd   = '0;
        ra_j = '0;
        for (int j = 0; j < NRD; j++) begin
            ra_j = ra[j*AW +: AW];
            if ((state_q == RUN) && ({1'b0, ra_j} < NREGS_W)
                && !((ZERO_REG != 0) && (ra_j == '0))) begin
                rd[j*XLEN +: XLEN] = mem_q[ra_j];
                if (BYPASS != 0) begin
                    for (int i = 0; i < NWR; i++) begin
                        if (wr_ok[i] && (wa[i*AW +: AW] == ra_j)) begin
                            rd[j*XLEN +: XLEN] = wd[i*XLEN +: XLEN];
                        end
                    end
                end
            end
        end
    end

endmodule
